// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch stage that sits directly in front of the core. It owns the
// fetch PC and reads one word at a time from instruction memory over a req/ack
// handshake, with at most one request outstanding. Returned words go into a
// small prefetch FIFO and are handed to the core with a valid/ready handshake.
// A redirect from the core flushes the FIFO and restarts fetch at the target.
//
// Handshakes:
//   core side  : the head moves to the core on any rising edge where
//                inst_valid && inst_ready. inst_ready is ignored while
//                inst_valid is low.
//   memory side: mem_req/mem_addr stay stable from the cycle they rise until
//                the edge on which mem_ack is high. mem_rdata is only sampled
//                on that edge. A request already issued cannot be withdrawn.
//
// Ports:
//   clk, n_rst               clock, asynchronous active-low reset
//   inst, inst_pc            FIFO head word and its address (NOP / 0 when idle)
//   inst_valid, inst_ready   core-side handshake
//   redirect, redirect_pc    fetch restart request and target (low bits ignored)
//   mem_req, mem_addr        instruction memory read request
//   mem_ack, mem_rdata       instruction memory response
//
// Optional build macro FETCH_BYPASS_EN: when the FIFO is empty, a word arriving
// from memory is presented to the core in its ack cycle (zero-cycle latency).
// If the core takes it that cycle, it is not written into the FIFO.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  // Address of the request being thrown away; fetch_pc_q already points at the
  // redirect target while the old request is still on the bus.
  logic [ADDR_WIDTH-1:0] drop_addr_q;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  head_valid;
  logic                  bypass_fire;
  logic                  push, pop, has_space;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign head_valid   = (count_q != '0);
  assign redirect_tgt = redirect_pc & ALIGN_M;

`ifdef FETCH_BYPASS_EN
  assign bypass_fire = !head_valid && (state_q == REQ) && mem_ack && !redirect;
`else
  assign bypass_fire = 1'b0;
`endif

  // A bypassed word the core accepts in the same cycle never enters the FIFO.
  assign push = (state_q == REQ) && mem_ack && !redirect &&
                !(bypass_fire && inst_ready);
  // Redirect discards any pop as well as any push on the flushing edge.
  assign pop  = head_valid && inst_ready && !redirect;

  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign has_space = (count_d < DEPTH_C);

  // Core-side outputs
  always_comb begin
    inst       = NOP;
    inst_pc    = '0;
    inst_valid = 1'b0;
    if (head_valid) begin
      inst       = data_q[rd_ptr_q];
      inst_pc    = pc_q[rd_ptr_q];
      inst_valid = 1'b1;
    end else if (bypass_fire) begin
      inst       = mem_rdata;
      inst_pc    = fetch_pc_q;
      inst_valid = 1'b1;
    end
  end

  // Memory-side outputs are decoded straight from registered state.
  assign mem_req  = (state_q != IDLE);
  assign mem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  // Fetch FSM and fetch PC
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_tgt;
            state_q    <= REQ;
          end else if (count_q != DEPTH_C) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc_q <= redirect_tgt;
            if (mem_ack) begin
              state_q <= REQ;
            end else begin
              // Request is still on the bus: hold its address until the ack.
              state_q     <= DROP;
              drop_addr_q <= fetch_pc_q;
            end
          end else if (mem_ack) begin
            fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
            state_q    <= has_space ? REQ : IDLE;
          end
        end
        DROP: begin
          if (redirect) fetch_pc_q <= redirect_tgt;
          // FIFO was flushed on entry and nothing is pushed here, so space exists.
          if (mem_ack) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Prefetch FIFO storage (payload needs no reset; count gates visibility)
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Prefetch FIFO pointers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// Directed bench for inst_fetch_queue. Memory returns addr ^ 32'hA5A5A5A5 for
// every read; inputs change 1 ns after a rising edge and outputs are checked at
// that same point, i.e. they reflect the state after the edge just taken.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        n_rst;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests_run;
  int fail_cnt;

  inst_fetch_queue dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents as a function of address
  assign mem_rdata = mem_addr ^ K;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst       = 1'b0;
    mem_ack     = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    step();
    n_rst = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    fail_cnt  = 0;

    // ---- reset state ----
    n_rst = 1'b0; mem_ack = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_mem_req",    32'(mem_req),    32'd0);
    chk("rst_mem_addr",   mem_addr,        32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst",       inst,            NOP);
    chk("rst_inst_pc",    inst_pc,         32'h0);
    do_reset();

    // ---- streaming: ack tied high, core always ready ----
    mem_ack = 1'b1; inst_ready = 1'b1;
    step();
    chk("s1_addr0",  mem_addr,        32'h0);
    chk("s1_req0",   32'(mem_req),    32'd1);
    chk("s1_valid0", 32'(inst_valid), 32'd0);
    step();
    chk("s1_addr1",  mem_addr, 32'h4);
    chk("s1_pc1",    inst_pc,  32'h0);
    chk("s1_inst1",  inst,     32'hA5A5_A5A5);
    step();
    chk("s1_addr2",  mem_addr, 32'h8);
    chk("s1_pc2",    inst_pc,  32'h4);
    chk("s1_inst2",  inst,     32'hA5A5_A5A1);
    step();
    chk("s1_addr3",  mem_addr, 32'hC);
    chk("s1_pc3",    inst_pc,  32'h8);
    chk("s1_inst3",  inst,     32'hA5A5_A5AD);

    // ---- fill to full with core stalled, then drain ----
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b0;
    step(); step(); step(); step(); step();
    chk("s2_full_req",   32'(mem_req),    32'd0);
    chk("s2_full_valid", 32'(inst_valid), 32'd1);
    chk("s2_full_pc",    inst_pc,         32'h0);
    step();
    chk("s2_full_req_hold", 32'(mem_req), 32'd0);
    inst_ready = 1'b1;
    step();
    chk("s2_pop_pc4", inst_pc,         32'h4);
    chk("s2_pop_req", 32'(mem_req),    32'd0);
    step();
    chk("s2_pop_pc8", inst_pc,         32'h8);
    chk("s2_resume_req",  32'(mem_req), 32'd1);
    chk("s2_resume_addr", mem_addr,     32'h10);
    step();
    chk("s2_pop_pcC",  inst_pc,  32'hC);
    chk("s2_addr14",   mem_addr, 32'h14);
    step();
    chk("s2_pop_pc10", inst_pc,  32'h10);

    // ---- redirect while a request is pending ----
    do_reset();
    mem_ack = 1'b1; inst_ready = 1'b1;
    step(); step(); step();
    chk("s3_pending_addr", mem_addr, 32'h8);
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("s3_drop_req",   32'(mem_req),    32'd1);
    chk("s3_drop_addr",  mem_addr,        32'h8);
    chk("s3_drop_valid", 32'(inst_valid), 32'd0);
    step();
    chk("s3_drop_hold",  mem_addr,        32'h8);
    mem_ack = 1'b1;
    step();
    chk("s3_new_addr",   mem_addr,        32'h100);
    chk("s3_discarded",  32'(inst_valid), 32'd0);
    step();
    chk("s3_first_valid", 32'(inst_valid), 32'd1);
    chk("s3_first_pc",    inst_pc,         32'h100);
    chk("s3_first_inst",  inst,            32'hA5A5_A4A5);

    // ---- redirect together with a pop and an ack ----
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    chk("s4_flush_valid", 32'(inst_valid), 32'd0);
    chk("s4_flush_inst",  inst,            NOP);
    chk("s4_flush_pc",    inst_pc,         32'h0);
    chk("s4_new_addr",    mem_addr,        32'h200);
    step();
    chk("s4_first_pc",    inst_pc,         32'h200);
    chk("s4_first_inst",  inst,            32'hA5A5_A7A5);

    // ---- asynchronous reset in the middle of a request ----
    n_rst = 1'b0;
    #2;
    chk("s5_async_req",   32'(mem_req),    32'd0);
    chk("s5_async_valid", 32'(inst_valid), 32'd0);
    chk("s5_async_addr",  mem_addr,        32'h0);
    n_rst = 1'b1;
    step();
    chk("s5_post_addr",   mem_addr,        32'h0);
    chk("s5_ack_ignored", 32'(inst_valid), 32'd0);

    // ---- fetch PC wraps at the top of the address space ----
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("s6_top_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("s6_wrap_addr", mem_addr,        32'h0);
    chk("s6_wrap_pc",   inst_pc,         32'hFFFF_FFFC);
    chk("s6_wrap_inst", inst,            32'h5A5A_5A59);
    chk("s6_wrap_valid", 32'(inst_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
